mul_seq_arbiter: RTL and testbench
==================================

Name: mul_seq_arbiter

Overview:
- Controller and two-port arbiter for the iterative 32-bit unsigned shift-add multiplier.
- The multiplier takes one multiplier bit per clock under a 6-bit operation code and publishes its product under the OUT code.
- This block grants one of two requesters, clears the multiplier, drives the MULTU code for exactly N_CYCLES clocks, then issues OUT.
- It captures the 64-bit product into HI/LO registers and returns a done pulse to the winning requester.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH.
- N_CYCLES, 32, number of MULTU iterations; must equal WIDTH.
- MULTU_CODE, 6'b011001, code that steps the multiplier.
- OUT_CODE, 6'b111111, code that makes the multiplier publish its product.
- IDLE_CODE, 6'b000000, code driven when no step is wanted (multiplier holds).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req0  in  1  requester 0 request; held high until done0
- a0  in  WIDTH  requester 0 multiplicand
- b0  in  WIDTH  requester 0 multiplier
- req1  in  1  requester 1 request; held high until done1
- a1  in  WIDTH  requester 1 multiplicand
- b1  in  WIDTH  requester 1 multiplier
- grant0  out  1  one-cycle pulse: req0 won, operands sampled
- grant1  out  1  one-cycle pulse: req1 won, operands sampled
- done0  out  1  one-cycle pulse: hi/lo valid for requester 0
- done1  out  1  one-cycle pulse: hi/lo valid for requester 1
- busy  out  1  high in every state except IDLE
- hi  out  WIDTH  product[63:32], held until the next capture
- lo  out  WIDTH  product[31:0], held until the next capture
- mul_reset  out  1  reset to the multiplier
- mul_signal  out  6  operation code to the multiplier
- mul_dataA  out  WIDTH  multiplicand to the multiplier
- mul_dataB  out  WIDTH  multiplier operand to the multiplier
- mul_dataOut  in  2*WIDTH  product from the multiplier

Behaviour:
- Reset values (synchronous, highest priority):
  - state=IDLE, rr_ptr=0, iteration counter=0.
  - hi=lo=0; grant*, done*, busy=0.
  - mul_signal=IDLE_CODE; mul_dataA=mul_dataB=0.
- mul_reset is combinational: mul_reset = reset OR (state==CLEAR). A reset asserted mid-operation therefore also clears the multiplier.
- States:
  - IDLE: arbitrate.
    - Eligible requester: reqN=1 and doneN=0 in that cycle.
    - One eligible requester: it wins.
    - Both eligible: the winner is rr_ptr (0 or 1).
    - On win: latch aN/bN into the operand registers, pulse grantN, record owner, set rr_ptr to the other requester, go to CLEAR.
    - No eligible requester: stay in IDLE, mul_signal=IDLE_CODE.
  - CLEAR (1 cycle): mul_reset=1, mul_signal=IDLE_CODE, operands driven; counter=0; go to RUN.
  - RUN (N_CYCLES cycles): mul_signal=MULTU_CODE, operands held stable; counter increments each cycle; after the cycle where counter==N_CYCLES-1, go to OUT.
  - OUT (1 cycle): mul_signal=OUT_CODE; go to CAPTURE.
  - CAPTURE (1 cycle): mul_signal=IDLE_CODE; {hi,lo} <= mul_dataOut; doneN <= 1 for the owner (registered); go to IDLE.
- Latency: grant pulse in cycle T0 (IDLE); done and valid hi/lo in cycle T0+N_CYCLES+4, i.e. 36 cycles later.
- Issue rate: the IDLE cycle carrying done may grant the other requester. Back-to-back issue is one operation per 36 cycles.
- Requester inputs are ignored outside IDLE. Operand changes after grant have no effect.
- Requests held continuously by both sides: grants alternate 0,1,0,1.
- Product width: full 64-bit unsigned; no overflow or truncation.
- A requester that drops req before its done still completes. hi/lo update and done pulses; the requester may ignore them.
- Zero operands need no special case: result is 0 at the same latency.

Optional Feature:
- Macro: MUL_SEQ_SIGNED_EN.
- Defined:
  - Adds inputs sgn0 and sgn1 (1 bit each), sampled with the operands at grant.
  - When the owner's sgn=1: operands are replaced by their absolute values before driving mul_dataA/B.
  - neg = a[31]^b[31] is recorded at grant.
  - In CAPTURE, {hi,lo} <= neg ? -mul_dataOut : mul_dataOut (two's complement, 64-bit).
  - Latency is unchanged.
  - Operand 0x80000000 has magnitude 0x80000000 and must produce the correct result.
- Undefined: sgn ports are absent; all operations are unsigned.

Test Plan:
- req0 with a0=3, b0=5 -> grant0 at T0; done0 at T0+36; hi=0x00000000, lo=0x0000000F; busy high T0+1..T0+35.
- req1 with a1=b1=0xFFFFFFFF -> done1; hi=0xFFFFFFFE, lo=0x00000001.
- req0 and req1 raised together after reset, both held (0x10000×0x10000 and 7×9) -> req0 served first, giving hi=0x00000001, lo=0; then req1 granted in req0's done cycle, giving lo=63; a third op goes to req0.
- Reset asserted during RUN at counter=10 -> next cycle state IDLE, busy=0, hi=lo=0, mul_reset=1 during reset, no done. A fresh 2×2 request then returns lo=4.
- a0=0, b0=0x12345678 -> lo=hi=0 at the normal 36-cycle latency.
- MUL_SEQ_SIGNED_EN defined:
  - sgn0=1, a0=0xFFFFFFFD (-3), b0=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - sgn0=1, a0=b0=0x80000000 -> hi=0x40000000, lo=0.

Source files
------------

// File: rtl/mul_seq_arbiter.sv
// Two-port arbiter and sequencer for the iterative shift-add multiplier: grant, clear, N_CYCLES steps, OUT, capture.
// Optional MUL_SEQ_SIGNED_EN adds per-request sgn inputs for signed operation via magnitude and result negation.
module mul_seq_arbiter #(
  parameter int           WIDTH      = 32,
  parameter int           N_CYCLES   = 32,
  parameter logic [5:0]   MULTU_CODE = 6'b011001,
  parameter logic [5:0]   OUT_CODE   = 6'b111111,
  parameter logic [5:0]   IDLE_CODE  = 6'b000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
`ifdef MUL_SEQ_SIGNED_EN
  input  logic               sgn0,
  input  logic               sgn1,
`endif
  output logic               grant0,
  output logic               grant1,
  output logic               done0,
  output logic               done1,
  output logic               busy,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               mul_reset,
  output logic [5:0]         mul_signal,
  output logic [WIDTH-1:0]   mul_dataA,
  output logic [WIDTH-1:0]   mul_dataB,
  input  logic [2*WIDTH-1:0] mul_dataOut
);

  localparam int CNT_W = $clog2(N_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_OUT, S_CAPTURE} state_t;

  state_t             state;
  logic               rr_ptr;
  logic               owner;
  logic [CNT_W-1:0]   cnt;
  logic               elig0, elig1, pick1, win;
  logic [WIDTH-1:0]   sel_a, sel_b, op_a, op_b;
  logic [2*WIDTH-1:0] result;

`ifdef MUL_SEQ_SIGNED_EN
  logic sel_sgn, sel_neg, neg;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_prod(input logic [2*WIDTH-1:0] p);
    return ~p + 1'b1;
  endfunction
`endif

  // Arbitration: a requester whose done is showing this cycle sits out, letting the other win.
  always_comb begin
    elig0  = req0 & ~done0;
    elig1  = req1 & ~done1;
    pick1  = elig1 & (~elig0 | rr_ptr);
    win    = (state == S_IDLE) & (elig0 | elig1);
    grant0 = win & ~pick1;
    grant1 = win & pick1;
    sel_a  = pick1 ? a1 : a0;
    sel_b  = pick1 ? b1 : b0;
`ifdef MUL_SEQ_SIGNED_EN
    sel_sgn = pick1 ? sgn1 : sgn0;
    sel_neg = sel_sgn & (sel_a[WIDTH-1] ^ sel_b[WIDTH-1]);
    op_a    = sel_sgn ? abs_val(sel_a) : sel_a;
    op_b    = sel_sgn ? abs_val(sel_b) : sel_b;
    result  = neg ? neg_prod(mul_dataOut) : mul_dataOut;
`else
    op_a    = sel_a;
    op_b    = sel_b;
    result  = mul_dataOut;
`endif
  end

  assign mul_reset = reset | (state == S_CLEAR);

  // mul_signal and busy are registered with the value belonging to the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      rr_ptr     <= 1'b0;
      owner      <= 1'b0;
      cnt        <= '0;
      hi         <= '0;
      lo         <= '0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      busy       <= 1'b0;
      mul_signal <= IDLE_CODE;
      mul_dataA  <= '0;
      mul_dataB  <= '0;
`ifdef MUL_SEQ_SIGNED_EN
      neg        <= 1'b0;
`endif
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win) begin
            mul_dataA  <= op_a;
            mul_dataB  <= op_b;
            owner      <= pick1;
            rr_ptr     <= ~pick1;
            busy       <= 1'b1;
            mul_signal <= IDLE_CODE;
            state      <= S_CLEAR;
`ifdef MUL_SEQ_SIGNED_EN
            neg        <= sel_neg;
`endif
          end
        end
        S_CLEAR: begin
          cnt        <= '0;
          mul_signal <= MULTU_CODE;
          state      <= S_RUN;
        end
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(N_CYCLES - 1)) begin
            mul_signal <= OUT_CODE;
            state      <= S_OUT;
          end
        end
        S_OUT: begin
          mul_signal <= IDLE_CODE;
          state      <= S_CAPTURE;
        end
        S_CAPTURE: begin
          {hi, lo} <= result;
          done0    <= ~owner;
          done1    <= owner;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          mul_signal <= IDLE_CODE;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_arbiter.sv
// Bench for mul_seq_arbiter: behavioural shift-add multiplier, grant-time scoreboard, per-scenario tasks.
module tb_mul_seq_arbiter;

  localparam int W = 32;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] OUTC  = 6'b111111;
  localparam logic [5:0] IDLEC = 6'b000000;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0]   a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic           sgn0 = 1'b0, sgn1 = 1'b0;
  logic           grant0, grant1, done0, done1, busy, mul_reset;
  logic [W-1:0]   hi, lo, mul_dataA, mul_dataB;
  logic [5:0]     mul_signal;
  logic [2*W-1:0] mul_dataOut;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {int id; logic [63:0] prod; int gcyc;} exp_t;
  exp_t sb[$];
  exp_t e;

  mul_seq_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
`ifdef MUL_SEQ_SIGNED_EN
    .sgn0(sgn0), .sgn1(sgn1),
`endif
    .grant0(grant0), .grant1(grant1), .done0(done0), .done1(done1),
    .busy(busy), .hi(hi), .lo(lo),
    .mul_reset(mul_reset), .mul_signal(mul_signal),
    .mul_dataA(mul_dataA), .mul_dataB(mul_dataB), .mul_dataOut(mul_dataOut)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural iterative multiplier; any step beyond the 32nd corrupts the accumulator.
  logic [63:0] acc;
  logic [6:0]  step;
  always_ff @(posedge clk) begin
    if (mul_reset) begin
      acc <= '0;
      step <= '0;
    end else if (mul_signal == MULTU) begin
      if (step >= 7'd32) acc <= acc ^ 64'h0000_DEAD_0000_BEEF;
      else if (mul_dataB[step[4:0]]) acc <= acc + ({32'b0, mul_dataA} << step[4:0]);
      step <= step + 1'b1;
    end else if (mul_signal == OUTC) begin
      mul_dataOut <= acc;
    end
  end

  function automatic logic [63:0] model_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] sa, sbv;
    if (s) begin
      sa  = {{32{a[31]}}, a};
      sbv = {{32{b[31]}}, b};
      return sa * sbv;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Scoreboard: push at grant, pop and compare at done.
  always @(negedge clk) begin
    if (reset) sb.delete();
    else begin
      if (done0 || done1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_done_unexpected: done0=%0b done1=%0b, none pending", done0, done1);
        end else begin
          e = sb.pop_front();
          if ((done1 ? 1 : 0) !== e.id) begin
            errors++;
            $display("FAIL sb_owner: got done for %0d, expected %0d", done1 ? 1 : 0, e.id);
          end
          checks++;
          if ({hi, lo} !== e.prod) begin
            errors++;
            $display("FAIL sb_product: got %h_%h, expected %h", hi, lo, e.prod);
          end
          checks++;
          if (cyc - e.gcyc !== 36) begin
            errors++;
            $display("FAIL sb_latency: got %0d cycles, expected 36", cyc - e.gcyc);
          end
        end
      end
      if (grant0 && grant1) begin
        checks++;
        errors++;
        $display("FAIL sb_double_grant: grant0=1 grant1=1, expected one");
      end
      if (grant0) sb.push_back('{0, model_prod(a0, b0, sgn0), cyc});
      if (grant1) sb.push_back('{1, model_prod(a1, b1, sgn1), cyc});
    end
  end

  task automatic run_single(input int id, input logic [31:0] a, input logic [31:0] b, input logic s);
    int busy_cnt;
    bit got_done;
    @(posedge clk); #1;
    if (id == 0) begin req0 = 1'b1; a0 = a; b0 = b; sgn0 = s; end
    else begin req1 = 1'b1; a1 = a; b1 = b; sgn1 = s; end
    @(negedge clk);
    checks++;
    if ((id == 0 ? grant0 : grant1) !== 1'b1) begin
      errors++;
      $display("FAIL single_grant%0d: got 0, expected 1", id);
    end
    busy_cnt = 0;
    got_done = 0;
    for (int i = 0; i < 60 && !got_done; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (busy) busy_cnt++;
      if ((id == 0 ? done0 : done1) === 1'b1) got_done = 1;
    end
    checks++;
    if (!got_done) begin
      errors++;
      $display("FAIL single_done%0d: no done within 60 cycles, expected one", id);
    end
    checks++;
    if (busy_cnt !== 35) begin
      errors++;
      $display("FAIL single_busy%0d: busy for %0d cycles, expected 35", id, busy_cnt);
    end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0; sgn0 = 1'b0; sgn1 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({busy, grant0, grant1, done0, done1} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy/grants/dones=%b, expected 00000", {busy, grant0, grant1, done0, done1});
    end
    checks++;
    if ({hi, lo} !== 64'h0) begin
      errors++;
      $display("FAIL reset_hilo: got %h_%h, expected 0", hi, lo);
    end
    checks++;
    if (mul_signal !== IDLEC || mul_dataA !== '0 || mul_dataB !== '0) begin
      errors++;
      $display("FAIL reset_mul: sig=%b A=%h B=%h, expected idle/0/0", mul_signal, mul_dataA, mul_dataB);
    end
    checks++;
    if (mul_reset !== 1'b1) begin
      errors++;
      $display("FAIL reset_mulreset: got %b, expected 1", mul_reset);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (mul_reset !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: mul_reset=%b busy=%b, expected 0 0", mul_reset, busy);
    end
  endtask

  task automatic test_unsigned();
    run_single(0, 32'd3, 32'd5, 1'b0);
    checks++;
    if (hi !== 32'h0 || lo !== 32'hF) begin
      errors++;
      $display("FAIL unsigned_3x5: got %h_%h, expected 00000000_0000000f", hi, lo);
    end
    run_single(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    checks++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      errors++;
      $display("FAIL unsigned_max: got %h_%h, expected fffffffe_00000001", hi, lo);
    end
  endtask

  task automatic test_zero();
    run_single(0, 32'd0, 32'h1234_5678, 1'b0);
    checks++;
    if ({hi, lo} !== 64'h0) begin
      errors++;
      $display("FAIL zero_operand: got %h_%h, expected 0", hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int order[$];
    int gc[$];
    bit got_done;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    a0 = 32'h0001_0000; b0 = 32'h0001_0000; a1 = 32'd7; b1 = 32'd9;
    for (int i = 0; i < 200 && order.size() < 3; i++) begin
      @(negedge clk);
      if (grant0) begin order.push_back(0); gc.push_back(cyc); end
      if (grant1) begin order.push_back(1); gc.push_back(cyc); end
      @(posedge clk); #1;
      if (order.size() >= 1) begin a0 = 32'd5; b0 = 32'd6; end
    end
    req0 = 1'b0; req1 = 1'b0;
    got_done = 0;
    for (int i = 0; i < 60 && !got_done; i++) begin
      @(negedge clk);
      if (done0) got_done = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (order.size() !== 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d grants, expected 3", order.size());
    end else begin
      checks++;
      if (order[0] !== 0 || order[1] !== 1 || order[2] !== 0) begin
        errors++;
        $display("FAIL b2b_order: got %0d,%0d,%0d, expected 0,1,0", order[0], order[1], order[2]);
      end
      checks++;
      if (gc[1] - gc[0] !== 36 || gc[2] - gc[1] !== 36) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d,%0d, expected 36,36", gc[1] - gc[0], gc[2] - gc[1]);
      end
    end
    checks++;
    if (!got_done || lo !== 32'd30) begin
      errors++;
      $display("FAIL b2b_third: done=%0b lo=%0d, expected 1 and 30", got_done, lo);
    end
  endtask

  task automatic test_reset_mid_run();
    bit saw_done;
    @(posedge clk); #1;
    req0 = 1'b1; a0 = 32'h1234; b0 = 32'h5678;
    @(negedge clk);
    checks++;
    if (grant0 !== 1'b1) begin
      errors++;
      $display("FAIL midrst_grant: got %b, expected 1", grant0);
    end
    repeat (12) @(posedge clk);
    #1;
    reset = 1'b1;
    req0 = 1'b0;
    @(negedge clk);
    checks++;
    if (mul_reset !== 1'b1) begin
      errors++;
      $display("FAIL midrst_mulreset: got %b, expected 1", mul_reset);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || {hi, lo} !== 64'h0 || mul_signal !== IDLEC) begin
      errors++;
      $display("FAIL midrst_state: busy=%b hilo=%h_%h sig=%b, expected 0 0 idle", busy, hi, lo, mul_signal);
    end
    saw_done = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done0 || done1) saw_done = 1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL midrst_nodone: got a done after reset, expected none");
    end
    run_single(0, 32'd2, 32'd2, 1'b0);
    checks++;
    if ({hi, lo} !== 64'd4) begin
      errors++;
      $display("FAIL midrst_fresh: got %h_%h, expected 4", hi, lo);
    end
  endtask

`ifdef MUL_SEQ_SIGNED_EN
  task automatic test_signed();
    run_single(0, 32'hFFFF_FFFD, 32'd7, 1'b1);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
      errors++;
      $display("FAIL signed_neg3x7: got %h_%h, expected ffffffff_ffffffeb", hi, lo);
    end
    run_single(0, 32'h8000_0000, 32'h8000_0000, 1'b1);
    checks++;
    if (hi !== 32'h4000_0000 || lo !== 32'h0) begin
      errors++;
      $display("FAIL signed_minsq: got %h_%h, expected 40000000_00000000", hi, lo);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_unsigned();
    test_zero();
    test_back_to_back();
    test_reset_mid_run();
`ifdef MUL_SEQ_SIGNED_EN
    test_signed();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL sb_drain: %0d results pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
